// File: rtl/pkt_rx_pkg.sv
// Shared types for the ingress packet parser: FSM states and the FIFO entry layout.
package pkt_rx_pkg;

  // DA, SA and LEN are stored ahead of the payload
  localparam int unsigned HDR_BYTES = 3;

  typedef enum logic [2:0] {
    StIdle,
    StSa,
    StLen,
    StPay,
    StPar
  } state_e;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } entry_t;

endpackage

// File: rtl/pkt_rx_parser_if.sv
// Ingress byte stream and egress show-ahead byte port of the packet parser.
interface pkt_rx_parser_if;
  logic       packet_in_start;
  logic [7:0] packet_in;
  logic       packet_ack;
  logic       drop_pulse;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       out_ready;

  // Parser side
  modport slave (
    input  packet_in_start, packet_in, out_ready,
    output packet_ack, drop_pulse, out_valid, out_data, out_sop, out_eop
  );

  // Driver / consumer side
  modport master (
    output packet_in_start, packet_in, out_ready,
    input  packet_ack, drop_pulse, out_valid, out_data, out_sop, out_eop
  );
endinterface

// File: rtl/pkt_fifo_rb.sv
// Store-and-forward byte FIFO with a speculative write pointer that is either
// committed (packet becomes readable) or rolled back (packet discarded).
module pkt_fifo_rb
  import pkt_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned PtrW       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en_i,
  input  entry_t          wr_entry_i,
  input  logic            commit_i,
  input  logic            rollback_i,
  output logic [PtrW-1:0] free_o,
  output logic            rd_valid_o,
  output entry_t          rd_entry_o,
  input  logic            rd_ready_i
);
  localparam int unsigned AddrW = PtrW - 1;

  entry_t          mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
  logic [PtrW-1:0] base;
  logic            full;
  logic            do_wr;

  // Pointer next-state; a rollback and a new write in the same cycle (packet
  // restart) write the new byte at the rolled-back position.
  always_comb begin
    base     = rollback_i ? commit_q : wr_q;
    // Guards committed-unread data from the header bytes written before the
    // space check at LEN; such a packet is always dropped at LEN anyway.
    full     = ((base - rd_q) == PtrW'(FIFO_DEPTH));
    do_wr    = wr_en_i & ~full;
    wr_d     = do_wr ? base + PtrW'(1) : base;
    commit_d = commit_i ? wr_q : commit_q;
    rd_d     = (rd_valid_o && rd_ready_i) ? rd_q + PtrW'(1) : rd_q;
  end

  // Pointer registers; reset empties the FIFO including committed data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q     <= '0;
      commit_q <= '0;
      rd_q     <= '0;
    end else begin
      wr_q     <= wr_d;
      commit_q <= commit_d;
      rd_q     <= rd_d;
    end
  end

  // Entry storage, no reset needed since validity comes from the pointers
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[base[AddrW-1:0]] <= wr_entry_i;
    end
  end

  // Show-ahead read port and committed-space report
  always_comb begin
    rd_valid_o = (rd_q != commit_q);
    rd_entry_o = mem_q[rd_q[AddrW-1:0]];
    free_o     = PtrW'(FIFO_DEPTH) - (commit_q - rd_q);
  end

endmodule

// File: rtl/pkt_rx_parser.sv
// Ingress parser: frames DA/SA/LEN/payload/PAR, checks XOR parity and either
// commits the stored packet to the FIFO or rolls it back.
module pkt_rx_parser
  import pkt_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned MAX_LEN    = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  pkt_rx_parser_if.slave   bus,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH) + 1;

  state_e          state_q, state_d;
  logic [7:0]      par_q, par_d;
  logic [7:0]      len_q, len_d;
  logic            drop_q, drop_d;
  logic            ack_q, ack_d;
  logic            dpulse_q, dpulse_d;
  logic [CNT_W-1:0] good_q, good_d, dcnt_q, dcnt_d;

  logic            wr_en, commit, rollback;
  entry_t          wr_entry;
  logic [PtrW-1:0] free;
  logic            rd_valid;
  entry_t          rd_entry;
  logic [7:0]      in_byte;

  assign in_byte = bus.packet_in;

  pkt_fifo_rb #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PtrW       (PtrW)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .wr_en_i    (wr_en),
    .wr_entry_i (wr_entry),
    .commit_i   (commit),
    .rollback_i (rollback),
    .free_o     (free),
    .rd_valid_o (rd_valid),
    .rd_entry_o (rd_entry),
    .rd_ready_i (bus.out_ready)
  );

  // Frame FSM, parity accumulation, FIFO write/commit/rollback and statistics
  always_comb begin
    state_d  = state_q;
    par_d    = par_q;
    len_d    = len_q;
    drop_d   = drop_q;
    ack_d    = 1'b0;
    dpulse_d = 1'b0;
    good_d   = good_q;
    dcnt_d   = dcnt_q;
    wr_en    = 1'b0;
    wr_entry = '{sop: 1'b0, eop: 1'b0, data: in_byte};
    commit   = 1'b0;
    rollback = 1'b0;

    if (bus.packet_in_start) begin
      // A start mid-frame abandons the current packet; the byte is a new DA
      if (state_q != StIdle) begin
        rollback = 1'b1;
        dpulse_d = 1'b1;
        dcnt_d   = (dcnt_q == '1) ? dcnt_q : dcnt_q + CNT_W'(1);
      end
      state_d      = StSa;
      par_d        = in_byte;
      drop_d       = 1'b0;
      wr_en        = 1'b1;
      wr_entry.sop = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StSa: begin
          par_d   = par_q ^ in_byte;
          wr_en   = ~drop_q;
          state_d = StLen;
        end
        StLen: begin
          par_d = par_q ^ in_byte;
          len_d = in_byte;
          // Space is judged against committed-unread entries only
          if ((32'(in_byte) > MAX_LEN) ||
              ((32'(in_byte) + HDR_BYTES) > 32'(free))) begin
            drop_d = 1'b1;
          end
          wr_en        = ~drop_d;
          wr_entry.eop = (in_byte == 8'd0);
          state_d      = (in_byte == 8'd0) ? StPar : StPay;
        end
        StPay: begin
          par_d        = par_q ^ in_byte;
          wr_en        = ~drop_q;
          wr_entry.eop = (len_q == 8'd1);
          len_d        = len_q - 8'd1;
          if (len_q == 8'd1) begin
            state_d = StPar;
          end
        end
        StPar: begin
          state_d = StIdle;
          if (!drop_q && (par_q == in_byte)) begin
            commit = 1'b1;
            ack_d  = 1'b1;
            good_d = (good_q == '1) ? good_q : good_q + CNT_W'(1);
          end else begin
            rollback = 1'b1;
            dpulse_d = 1'b1;
            dcnt_d   = (dcnt_q == '1) ? dcnt_q : dcnt_q + CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and statistics registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      par_q    <= '0;
      len_q    <= '0;
      drop_q   <= 1'b0;
      ack_q    <= 1'b0;
      dpulse_q <= 1'b0;
      good_q   <= '0;
      dcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      par_q    <= par_d;
      len_q    <= len_d;
      drop_q   <= drop_d;
      ack_q    <= ack_d;
      dpulse_q <= dpulse_d;
      good_q   <= good_d;
      dcnt_q   <= dcnt_d;
    end
  end

  // Egress view; data is forced to zero when nothing is committed
  always_comb begin
    bus.packet_ack = ack_q;
    bus.drop_pulse = dpulse_q;
    bus.out_valid  = rd_valid;
    bus.out_data   = rd_valid ? rd_entry.data : 8'h00;
    bus.out_sop    = rd_valid & rd_entry.sop;
    bus.out_eop    = rd_valid & rd_entry.eop;
    good_cnt       = good_q;
    drop_cnt       = dcnt_q;
  end

endmodule

// File: tb/tb_pkt_rx_parser.sv
// Self-checking bench for pkt_rx_parser with a queue-based packet model.
module tb_pkt_rx_parser;
  import pkt_rx_pkg::*;

  localparam int unsigned FIFO_DEPTH = 64;
  localparam int unsigned MAX_LEN    = 32;
  localparam int unsigned CNT_W      = 16;

  typedef logic [7:0] bq_t [$];

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] good_cnt, drop_cnt;

  pkt_rx_parser_if bus ();

  pkt_rx_parser #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_LEN    (MAX_LEN),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .good_cnt (good_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  entry_t exp_q[$];
  entry_t rx_q[$];
  int     ack_seen, drop_seen, good_m, drop_m;
  int     n_checks, n_fail;
  bit     rand_ready;

  // Capture transfers and pulses half a cycle away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      if (bus.out_valid && bus.out_ready)
        rx_q.push_back(entry_t'{sop: bus.out_sop, eop: bus.out_eop, data: bus.out_data});
      if (bus.packet_ack) ack_seen++;
      if (bus.drop_pulse) drop_seen++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Packet is accepted iff complete, legal length, room for it, and XOR parity holds
  function automatic bit model_accept(input bq_t p, input int unread);
    logic [7:0] x;
    int n;
    if (p.size() < 4) return 1'b0;
    n = int'(p[2]);
    if (p.size() != n + 4) return 1'b0;
    if (n > int'(MAX_LEN)) return 1'b0;
    if (unread + n + 3 > int'(FIFO_DEPTH)) return 1'b0;
    x = 8'h00;
    for (int i = 0; i < p.size() - 1; i++) x ^= p[i];
    return x == p[p.size()-1];
  endfunction

  function automatic int first_diff();
    int n;
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) return i;
    if (rx_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic build_pkt(input int n, input bit bad, output bq_t p);
    logic [7:0] x;
    p = {};
    p.push_back(8'($urandom));
    p.push_back(8'($urandom));
    p.push_back(8'(n));
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    x = 8'h00;
    foreach (p[i]) x ^= p[i];
    if (bad) x ^= 8'($urandom_range(1, 255));
    p.push_back(x);
  endtask

  task automatic send(input bq_t p);
    foreach (p[i]) begin
      @(posedge clk);
      #1;
      bus.packet_in_start = (i == 0);
      bus.packet_in       = p[i];
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.packet_in_start = 1'b0;
      bus.packet_in       = 8'($urandom);
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send_model(input bq_t p);
    int unread;
    unread = exp_q.size() - rx_q.size();
    if (model_accept(p, unread)) begin
      for (int i = 0; i < p.size() - 1; i++)
        exp_q.push_back(entry_t'{sop: (i == 0), eop: (i == p.size() - 2), data: p[i]});
      good_m++;
    end else begin
      drop_m++;
    end
    send(p);
  endtask

  task automatic drain();
    int t;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    t = 0;
    while (rx_q.size() < exp_q.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.packet_in_start = 1'b0;
    bus.packet_in       = 8'h00;
    bus.out_ready       = 1'b1;
    rand_ready          = 1'b0;
    rst                 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q = {}; rx_q = {};
    ack_seen = 0; drop_seen = 0; good_m = 0; drop_m = 0;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks += 5;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    if (bus.packet_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.packet_ack); end
    if (bus.drop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", bus.drop_pulse); end
    if (good_cnt !== '0) begin n_fail++; $display("FAIL reset_good_cnt: got %0d want 0", good_cnt); end
    if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_good();
    bq_t p;
    int  d;
    do_reset();
    p = '{8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'hDB};
    send_model(p);
    idle(1);
    @(negedge clk);
    n_checks += 4;
    if (bus.packet_ack !== 1'b1) begin n_fail++; $display("FAIL good_ack: got %b want 1", bus.packet_ack); end
    if (bus.drop_pulse !== 1'b0) begin n_fail++; $display("FAIL good_nodrop: got %b want 0", bus.drop_pulse); end
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h12) begin
      n_fail++; $display("FAIL good_visible: valid=%b data=%h want 1/12", bus.out_valid, bus.out_data);
    end
    if (bus.out_sop !== 1'b1) begin n_fail++; $display("FAIL good_sop: got %b want 1", bus.out_sop); end
    idle(1);
    @(negedge clk);
    n_checks++;
    if (bus.packet_ack !== 1'b0) begin n_fail++; $display("FAIL good_ack_width: got %b want 0", bus.packet_ack); end
    drain();
    d = first_diff();
    n_checks += 2;
    if (d != -1) begin n_fail++; $display("FAIL good_stream: idx %0d got %h want %h", d, rx_q[d], exp_q[d]); end
    if (good_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL good_cnt: got %0d want 1", good_cnt); end
  endtask

  task automatic test_bad_parity();
    bq_t p;
    int  d;
    do_reset();
    p = '{8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'h00};
    send_model(p);
    idle(1);
    @(negedge clk);
    n_checks += 3;
    if (bus.drop_pulse !== 1'b1) begin n_fail++; $display("FAIL badpar_drop: got %b want 1", bus.drop_pulse); end
    if (bus.packet_ack !== 1'b0) begin n_fail++; $display("FAIL badpar_ack: got %b want 0", bus.packet_ack); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL badpar_valid: got %b want 0", bus.out_valid); end
    build_pkt($urandom_range(1, 10), 1'b0, p);
    send_model(p);
    idle(2);
    drain();
    d = first_diff();
    n_checks += 3;
    if (d != -1) begin n_fail++; $display("FAIL badpar_stream: idx %0d got %h want %h", d, rx_q[d], exp_q[d]); end
    if (drop_cnt !== CNT_W'(drop_m)) begin n_fail++; $display("FAIL badpar_drop_cnt: got %0d want %0d", drop_cnt, drop_m); end
    if (good_cnt !== CNT_W'(good_m)) begin n_fail++; $display("FAIL badpar_good_cnt: got %0d want %0d", good_cnt, good_m); end
  endtask

  task automatic test_oversize();
    bq_t p, q;
    int  d;
    do_reset();
    build_pkt(33, 1'b0, p);
    build_pkt(5, 1'b0, q);
    send_model(p);
    send_model(q);
    idle(2);
    drain();
    d = first_diff();
    n_checks += 4;
    if (d != -1) begin n_fail++; $display("FAIL oversize_stream: idx %0d got %h want %h", d, rx_q[d], exp_q[d]); end
    if (drop_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL oversize_drop_cnt: got %0d want 1", drop_cnt); end
    if (good_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL oversize_good_cnt: got %0d want 1", good_cnt); end
    if (drop_seen != 1 || ack_seen != 1) begin
      n_fail++; $display("FAIL oversize_pulses: drop=%0d ack=%0d want 1/1", drop_seen, ack_seen);
    end
  endtask

  task automatic test_restart();
    bq_t a, t, b;
    int  d;
    do_reset();
    build_pkt(4, 1'b0, a);
    t = a[0:3];
    build_pkt(5, 1'b0, b);
    send_model(t);
    send_model(b);
    idle(2);
    drain();
    d = first_diff();
    n_checks += 4;
    if (d != -1) begin n_fail++; $display("FAIL restart_stream: idx %0d got %h want %h", d, rx_q[d], exp_q[d]); end
    if (drop_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL restart_drop_cnt: got %0d want 1", drop_cnt); end
    if (good_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL restart_good_cnt: got %0d want 1", good_cnt); end
    if (drop_seen != 1 || ack_seen != 1) begin
      n_fail++; $display("FAIL restart_pulses: drop=%0d ack=%0d want 1/1", drop_seen, ack_seen);
    end
  endtask

  task automatic test_full();
    bq_t p;
    int  d;
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      build_pkt(28, 1'b0, p);
      send_model(p);
      idle(1);
    end
    idle(2);
    @(negedge clk);
    n_checks += 3;
    if (good_cnt !== CNT_W'(2)) begin n_fail++; $display("FAIL full_good_cnt: got %0d want 2", good_cnt); end
    if (drop_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL full_drop_cnt: got %0d want 1", drop_cnt); end
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", bus.out_valid); end
    drain();
    d = first_diff();
    n_checks += 3;
    if (d != -1) begin n_fail++; $display("FAIL full_stream: idx %0d got %h want %h", d, rx_q[d], exp_q[d]); end
    if (rx_q.size() != 62) begin
      n_fail++; $display("FAIL full_count: got %0d bytes want 62", rx_q.size());
    end else if (rx_q[30].eop !== 1'b1 || rx_q[61].eop !== 1'b1 || rx_q[31].sop !== 1'b1) begin
      n_fail++; $display("FAIL full_eop: eop30=%b eop61=%b sop31=%b want 1/1/1",
                         rx_q[30].eop, rx_q[61].eop, rx_q[31].sop);
    end
    if (ack_seen != 2 || drop_seen != 1) begin
      n_fail++; $display("FAIL full_pulses: ack=%0d drop=%0d want 2/1", ack_seen, drop_seen);
    end
  endtask

  task automatic test_len0();
    bq_t p;
    int  d;
    do_reset();
    p = '{8'h01, 8'h02, 8'h00, 8'h03};
    send_model(p);
    idle(2);
    drain();
    d = first_diff();
    n_checks += 2;
    if (d != -1) begin n_fail++; $display("FAIL len0_stream: idx %0d got %h want %h", d, rx_q[d], exp_q[d]); end
    if (rx_q.size() != 3) begin
      n_fail++; $display("FAIL len0_count: got %0d bytes want 3", rx_q.size());
    end else if (rx_q[2] !== entry_t'{sop: 1'b0, eop: 1'b1, data: 8'h00}) begin
      n_fail++; $display("FAIL len0_eop: got %h want 100", rx_q[2]);
    end
  endtask

  task automatic test_random();
    bq_t p, a, t;
    int  d;
    do_reset();
    rand_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        build_pkt($urandom_range(0, 12), 1'b0, a);
        t = a[0:$urandom_range(0, a.size() - 2)];
        send_model(t);
      end
      build_pkt($urandom_range(0, 40), ($urandom_range(0, 4) == 0), p);
      send_model(p);
      idle($urandom_range(1, 3));
      drain();
      rand_ready = 1'b1;
    end
    d = first_diff();
    n_checks += 4;
    if (d != -1) begin n_fail++; $display("FAIL random_stream: idx %0d got %h want %h", d, rx_q[d], exp_q[d]); end
    if (good_cnt !== CNT_W'(good_m)) begin n_fail++; $display("FAIL random_good_cnt: got %0d want %0d", good_cnt, good_m); end
    if (drop_cnt !== CNT_W'(drop_m)) begin n_fail++; $display("FAIL random_drop_cnt: got %0d want %0d", drop_cnt, drop_m); end
    if (ack_seen != good_m || drop_seen != drop_m) begin
      n_fail++; $display("FAIL random_pulses: ack=%0d drop=%0d want %0d/%0d", ack_seen, drop_seen, good_m, drop_m);
    end
  endtask

  task automatic test_back_to_back();
    bq_t p;
    int  d;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      build_pkt($urandom_range(0, 8), (k == 2 || k == 4), p);
      send_model(p);
    end
    idle(2);
    drain();
    d = first_diff();
    n_checks += 4;
    if (d != -1) begin n_fail++; $display("FAIL b2b_stream: idx %0d got %h want %h", d, rx_q[d], exp_q[d]); end
    if (good_cnt !== CNT_W'(4)) begin n_fail++; $display("FAIL b2b_good_cnt: got %0d want 4", good_cnt); end
    if (drop_cnt !== CNT_W'(2)) begin n_fail++; $display("FAIL b2b_drop_cnt: got %0d want 2", drop_cnt); end
    if (ack_seen != 4 || drop_seen != 2) begin
      n_fail++; $display("FAIL b2b_pulses: ack=%0d drop=%0d want 4/2", ack_seen, drop_seen);
    end
  endtask

  task automatic test_async_reset();
    bq_t p, q;
    int  d;
    do_reset();
    bus.out_ready = 1'b0;
    build_pkt(3, 1'b0, p);
    send_model(p);
    idle(2);
    build_pkt(10, 1'b0, q);
    q = q[0:5];
    send(q);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %b want 1", bus.out_valid); end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_checks += 4;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      n_fail++; $display("FAIL areset_out: valid=%b data=%h want 0/00", bus.out_valid, bus.out_data);
    end
    if (bus.out_sop !== 1'b0 || bus.out_eop !== 1'b0) begin
      n_fail++; $display("FAIL areset_flags: sop=%b eop=%b want 0/0", bus.out_sop, bus.out_eop);
    end
    if (bus.packet_ack !== 1'b0 || bus.drop_pulse !== 1'b0) begin
      n_fail++; $display("FAIL areset_pulses: ack=%b drop=%b want 0/0", bus.packet_ack, bus.drop_pulse);
    end
    if (good_cnt !== '0 || drop_cnt !== '0) begin
      n_fail++; $display("FAIL areset_cnt: good=%0d drop=%0d want 0/0", good_cnt, drop_cnt);
    end
    bus.packet_in_start = 1'b0;
    @(posedge clk);
    #1;
    exp_q = {}; rx_q = {};
    ack_seen = 0; drop_seen = 0; good_m = 0; drop_m = 0;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    p = '{8'h01, 8'h02, 8'h00, 8'h03};
    send_model(p);
    idle(2);
    drain();
    d = first_diff();
    n_checks += 2;
    if (d != -1) begin n_fail++; $display("FAIL areset_stream: idx %0d got %h want %h", d, rx_q[d], exp_q[d]); end
    if (good_cnt !== CNT_W'(1) || drop_cnt !== '0) begin
      n_fail++; $display("FAIL areset_after_cnt: good=%0d drop=%0d want 1/0", good_cnt, drop_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.packet_in_start = 1'b0;
    bus.packet_in       = 8'h00;
    bus.out_ready       = 1'b1;
    rand_ready          = 1'b0;
    test_reset();
    test_good();
    test_bad_parity();
    test_oversize();
    test_restart();
    test_full();
    test_len0();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
